sga_turn_queue: RTL and testbench

// - Parametrised successor to the direction logic of the Snake Game control unit: registers turn commands

---
 rtl/sga_pkg.sv | 30 +++
 rtl/sga_turn_queue_if.sv | 42 ++++
 rtl/sga_dir_fifo.sv | 84 ++++++++
 rtl/sga_turn_queue.sv | 179 +++++++++++++++++
 tb/tb_sga_turn_queue.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sga_pkg
// Purpose  : Shared types for the turn queue: direction encodings, FSM
//            states and the opposite-direction helper.
// Revision : 1.0 - initial release
// ============================================================================
package sga_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_RIGHT = 2'b00;
    localparam dir_t DIR_LEFT  = 2'b01;
    localparam dir_t DIR_DOWN  = 2'b10;
    localparam dir_t DIR_UP    = 2'b11;

    // Encoded so the value can be driven straight onto the debug port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_t;

    // Opposite directions differ only in the low bit.
    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sga_turn_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : sga_turn_queue_if
// Purpose  : Control, button and status bundle of the turn queue.
//            master : game controller / button side (drives controls)
//            slave  : turn queue (drives direction, q_count, dropped, db_state)
// Ports    : start/pause/stop/step, init_dir, left/right/up/down (to slave);
//            direction, q_count, dropped, db_state (from slave)
// Revision : 1.0 - initial release
// ============================================================================
interface sga_turn_queue_if #(
    parameter int PLAYERS = 1,
    parameter int DEPTH   = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                       start;
    logic                       pause;
    logic                       stop;
    logic                       step;
    logic [2*PLAYERS-1:0]       init_dir;
    logic [PLAYERS-1:0]         left;
    logic [PLAYERS-1:0]         right;
    logic [PLAYERS-1:0]         up;
    logic [PLAYERS-1:0]         down;
    logic [2*PLAYERS-1:0]       direction;
    logic [CNT_W*PLAYERS-1:0]   q_count;
    logic [PLAYERS-1:0]         dropped;
    logic [1:0]                 db_state;

    modport master (
        output start, pause, stop, step, init_dir, left, right, up, down,
        input  direction, q_count, dropped, db_state
    );

    modport slave (
        input  start, pause, stop, step, init_dir, left, right, up, down,
        output direction, q_count, dropped, db_state
    );

endinterface
`default_nettype wire

// File: rtl/sga_dir_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sga_dir_fifo
// Purpose  : DEPTH-entry FIFO of 2-bit directions for one player. Exposes
//            the oldest entry (head) and the most recently written one
//            (newest) so the caller can validate a turn against the last
//            queued move.
// Ports    : clock, restart, clear, push, pop, din -> head, newest, count,
//            full, empty
// Revision : 1.0 - initial release
// ============================================================================
module sga_dir_fifo
    import sga_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             restart,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  dir_t             din,
    output dir_t             head,
    output dir_t             newest,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_last = PTR_W'(DEPTH - 1);

    dir_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_do_pop;
    logic             w_do_push;
    logic [PTR_W-1:0] w_newest_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_last) ? '0 : p + 1'b1;
    endfunction

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;

    // A full FIFO may accept a push only when a pop frees a slot this cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign w_newest_ptr = (r_wr_ptr == '0) ? c_last : r_wr_ptr - 1'b1;
    assign head         = r_mem[r_rd_ptr];
    assign newest       = r_mem[w_newest_ptr];

    always_ff @(posedge clock) begin
        if (restart || clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DIR_RIGHT;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sga_turn_queue.sv
`default_nettype none
// ============================================================================
// Module   : sga_turn_queue
// Purpose  : Per-player turn buffering for the snake game. Detects button
//            edges, rejects reversals and repeats, queues up to DEPTH turns
//            per player and releases one turn per move tick.
// Ports    : clock, restart (sync, active high), bus (sga_turn_queue_if.slave)
// Revision : 1.0 - initial release
// ============================================================================
module sga_turn_queue
    import sga_pkg::*;
#(
    parameter int PLAYERS = 1,
    parameter int DEPTH   = 2
) (
    input  logic            clock,
    input  logic            restart,
    sga_turn_queue_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t r_state;
    state_t w_state_next;
    logic   w_launch;   // IDLE -> RUN: load start directions, flush queues
    logic   w_active;   // commands are evaluated this cycle
    logic   w_step;     // move tick takes effect this cycle

    logic [PLAYERS-1:0] r_prev_up;
    logic [PLAYERS-1:0] r_prev_down;
    logic [PLAYERS-1:0] r_prev_left;
    logic [PLAYERS-1:0] r_prev_right;

    // ------------------------------------------------------------------
    // Game FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (restart) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_active     = 1'b0;
        w_step       = 1'b0;
        if (bus.stop) begin
            // Game over: queued turns and ticks in this cycle are moot.
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_state_next = ST_RUN;
                        w_launch     = 1'b1;
                    end
                end
                ST_RUN: begin
                    w_active = 1'b1;
                    w_step   = bus.step && !bus.pause;
                    if (bus.pause) begin
                        w_state_next = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (bus.start) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign bus.db_state = r_state;

    // Edge registers track the buttons in every state so a button held
    // across a pause or game start does not fire later.
    always_ff @(posedge clock) begin
        if (restart) begin
            r_prev_up    <= '0;
            r_prev_down  <= '0;
            r_prev_left  <= '0;
            r_prev_right <= '0;
        end else begin
            r_prev_up    <= bus.up;
            r_prev_down  <= bus.down;
            r_prev_left  <= bus.left;
            r_prev_right <= bus.right;
        end
    end

    // ------------------------------------------------------------------
    // Per-player turn handling
    // ------------------------------------------------------------------
    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        dir_t             r_dir;
        logic             r_dropped;
        dir_t             w_cmd;
        logic             w_has_cmd;
        dir_t             w_ref;
        logic             w_valid;
        logic             w_push;
        logic             w_pop;
        dir_t             w_head;
        dir_t             w_newest;
        logic [CNT_W-1:0] w_count;
        logic             w_full;
        logic             w_empty;

        // Same-cycle edges resolve as up > down > left > right.
        always_comb begin
            w_cmd     = DIR_RIGHT;
            w_has_cmd = 1'b1;
            if (bus.up[p] && !r_prev_up[p]) begin
                w_cmd = DIR_UP;
            end else if (bus.down[p] && !r_prev_down[p]) begin
                w_cmd = DIR_DOWN;
            end else if (bus.left[p] && !r_prev_left[p]) begin
                w_cmd = DIR_LEFT;
            end else if (bus.right[p] && !r_prev_right[p]) begin
                w_cmd = DIR_RIGHT;
            end else begin
                w_has_cmd = 1'b0;
            end
        end

        // A turn is judged against the last move it will follow.
        assign w_ref   = w_empty ? r_dir : w_newest;
        assign w_valid = w_active && w_has_cmd &&
                         (w_cmd != w_ref) && (w_cmd != opposite(w_ref));

        assign w_pop  = w_step && !w_empty;
        // Empty queue with a tick: the command bypasses the queue.
        assign w_push = w_valid && !(w_step && w_empty) && (!w_full || w_step);

        sga_dir_fifo #(
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clock   (clock),
            .restart (restart),
            .clear   (w_launch),
            .push    (w_push),
            .pop     (w_pop),
            .din     (w_cmd),
            .head    (w_head),
            .newest  (w_newest),
            .count   (w_count),
            .full    (w_full),
            .empty   (w_empty)
        );

        always_ff @(posedge clock) begin
            if (restart) begin
                r_dir     <= DIR_RIGHT;
                r_dropped <= 1'b0;
            end else begin
                r_dropped <= w_valid && w_full && !w_step;
                if (w_launch) begin
                    r_dir <= bus.init_dir[2*p +: 2];
                end else if (w_pop) begin
                    r_dir <= w_head;
                end else if (w_step && w_valid) begin
                    r_dir <= w_cmd;
                end
            end
        end

        assign bus.direction[2*p +: 2]     = r_dir;
        assign bus.q_count[CNT_W*p +: CNT_W] = w_count;
        assign bus.dropped[p]              = r_dropped;
    end

endmodule
`default_nettype wire

// File: tb/tb_sga_turn_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_sga_turn_queue
// Purpose  : Self-checking bench for sga_turn_queue (2 players, depth 2).
//            Directed scenarios followed by random stimulus, every cycle
//            compared against a queue-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sga_turn_queue;

    localparam int PLAYERS = 2;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic clock = 1'b0;
    logic restart;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sga_turn_queue_if #(.PLAYERS(PLAYERS), .DEPTH(DEPTH)) bus ();

    sga_turn_queue #(.PLAYERS(PLAYERS), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .restart (restart),
        .bus     (bus.slave)
    );

    // ---------------- reference model ----------------
    int         m_state;                 // 0 idle, 1 run, 2 paused
    logic [1:0] m_dir  [PLAYERS];
    logic [1:0] m_q    [PLAYERS][DEPTH]; // m_q[p][0] is the oldest turn
    int         m_n    [PLAYERS];
    logic       m_drop [PLAYERS];
    logic [3:0] m_prev [PLAYERS];        // {up, down, left, right}

    function automatic logic [1:0] prio_cmd(input logic [3:0] e);
        if (e[3]) return 2'b11;
        if (e[2]) return 2'b10;
        if (e[1]) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_update();
        logic [3:0] btn;
        logic [3:0] e;
        logic [1:0] cmd;
        logic [1:0] rf;
        bit         valid;
        bit         run_now;
        bit         stp;
        if (restart) begin
            m_state = 0;
            for (int p = 0; p < PLAYERS; p++) begin
                m_dir[p] = 2'b00; m_n[p] = 0; m_drop[p] = 1'b0; m_prev[p] = 4'b0;
            end
            return;
        end
        run_now = (m_state == 1) && !bus.stop;
        stp     = run_now && bus.step && !bus.pause;
        for (int p = 0; p < PLAYERS; p++) begin
            btn       = {bus.up[p], bus.down[p], bus.left[p], bus.right[p]};
            e         = btn & ~m_prev[p];
            m_prev[p] = btn;
            m_drop[p] = 1'b0;
            valid     = 1'b0;
            cmd       = prio_cmd(e);
            if (run_now && e != 4'b0) begin
                rf    = (m_n[p] > 0) ? m_q[p][m_n[p]-1] : m_dir[p];
                valid = (cmd != rf) && (cmd != (rf ^ 2'b01));
            end
            if (stp) begin
                if (m_n[p] > 0) begin
                    m_dir[p] = m_q[p][0];
                    for (int i = 0; i < DEPTH - 1; i++) m_q[p][i] = m_q[p][i+1];
                    m_n[p]--;
                    if (valid) begin m_q[p][m_n[p]] = cmd; m_n[p]++; end
                end else if (valid) begin
                    m_dir[p] = cmd;
                end
            end else if (valid) begin
                if (m_n[p] < DEPTH) begin m_q[p][m_n[p]] = cmd; m_n[p]++; end
                else m_drop[p] = 1'b1;
            end
        end
        if (bus.stop) m_state = 0;
        else if (m_state == 0 && bus.start) begin
            m_state = 1;
            for (int p = 0; p < PLAYERS; p++) begin
                m_dir[p] = bus.init_dir[2*p +: 2];
                m_n[p]   = 0;
            end
        end else if (m_state == 1 && bus.pause) m_state = 2;
        else if (m_state == 2 && bus.start) m_state = 1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ":db_state"}, 8'(bus.db_state), 8'(m_state));
        for (int p = 0; p < PLAYERS; p++) begin
            chk($sformatf("%s:dir%0d", tag, p), 8'(bus.direction[2*p +: 2]), 8'(m_dir[p]));
            chk($sformatf("%s:cnt%0d", tag, p), 8'(bus.q_count[CNT_W*p +: CNT_W]), 8'(m_n[p]));
            chk($sformatf("%s:drop%0d", tag, p), 8'(bus.dropped[p]), 8'(m_drop[p]));
        end
    endtask

    task automatic tick(input string tag);
        model_update();
        @(posedge clock);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.pause = 0; bus.stop = 0; bus.step = 0;
        bus.up = '0; bus.down = '0; bus.left = '0; bus.right = '0;
    endtask

    task automatic new_game(input logic [2*PLAYERS-1:0] init);
        restart = 1; tick("restart"); restart = 0;
        bus.init_dir = init; bus.start = 1; tick("start"); bus.start = 0;
    endtask

    initial begin
        restart = 1;
        idle_inputs();
        bus.init_dir = '0;
        tick("reset");
        chk("reset_state", 8'(bus.db_state), 8'h00);
        chk("reset_dir", 8'(bus.direction), 8'h00);
        chk("reset_cnt", 8'(bus.q_count), 8'h00);
        restart = 0;

        // 1: start loads init_dir
        bus.init_dir = 4'b0011; bus.start = 1; tick("t1"); bus.start = 0;
        chk("t1_dir", 8'(bus.direction[1:0]), 8'h3);
        chk("t1_state", 8'(bus.db_state), 8'h1);
        chk("t1_cnt", 8'(bus.q_count[1:0]), 8'h0);

        // 2: up then left queued, released one per step
        new_game('0);
        bus.up[0] = 1; tick("t2_up"); bus.up[0] = 0;
        bus.left[0] = 1; tick("t2_left"); bus.left[0] = 0;
        chk("t2_cnt", 8'(bus.q_count[1:0]), 8'h2);
        bus.step = 1; tick("t2_s1");
        chk("t2_s1_dir", 8'(bus.direction[1:0]), 8'h3);
        tick("t2_s2");
        chk("t2_s2_dir", 8'(bus.direction[1:0]), 8'h1);
        tick("t2_s3"); bus.step = 0;
        chk("t2_s3_dir", 8'(bus.direction[1:0]), 8'h1);

        // 3: reversal ignored, held button gives one command
        new_game('0);
        bus.left[0] = 1; tick("t3_rev"); bus.left[0] = 0;
        chk("t3_cnt", 8'(bus.q_count[1:0]), 8'h0);
        chk("t3_drop", 8'(bus.dropped[0]), 8'h0);
        chk("t3_dir", 8'(bus.direction[1:0]), 8'h0);
        bus.up[0] = 1;
        for (int i = 0; i < 5; i++) tick("t3_hold");
        bus.up[0] = 0;
        chk("t3_hold_cnt", 8'(bus.q_count[1:0]), 8'h1);
        tick("t3_rel");

        // 4: full queue drops without step, not with step
        bus.left[0] = 1; tick("t4_a"); bus.left[0] = 0; tick("t4_a_rel");
        bus.down[0] = 1; tick("t4_full"); bus.down[0] = 0;
        chk("t4_drop", 8'(bus.dropped[0]), 8'h1);
        chk("t4_cnt", 8'(bus.q_count[1:0]), 8'h2);
        tick("t4_after");
        chk("t4_drop_end", 8'(bus.dropped[0]), 8'h0);
        bus.up[0] = 1; bus.step = 1; tick("t4_step"); bus.up[0] = 0; bus.step = 0;
        chk("t4_step_drop", 8'(bus.dropped[0]), 8'h0);
        chk("t4_step_cnt", 8'(bus.q_count[1:0]), 8'h2);
        chk("t4_step_dir", 8'(bus.direction[1:0]), 8'h3);

        // 5: bypass
        new_game('0);
        bus.down[0] = 1; bus.step = 1; tick("t5"); bus.down[0] = 0; bus.step = 0;
        chk("t5_dir", 8'(bus.direction[1:0]), 8'h2);
        chk("t5_cnt", 8'(bus.q_count[1:0]), 8'h0);

        // 6: pause discards edges; players independent; stop
        bus.pause = 1; tick("t6_pause"); bus.pause = 0;
        chk("t6_paused", 8'(bus.db_state), 8'h2);
        bus.up[0] = 1; tick("t6_up");
        bus.start = 1; tick("t6_resume"); bus.start = 0;
        bus.step = 1; tick("t6_step"); bus.step = 0; bus.up[0] = 0;
        chk("t6_dir", 8'(bus.direction[1:0]), 8'h2);
        bus.up[1] = 1; tick("t6_p1"); bus.up[1] = 0;
        bus.step = 1; tick("t6_p1_step"); bus.step = 0;
        chk("t6_p1_dir", 8'(bus.direction[3:2]), 8'h3);
        chk("t6_p0_dir", 8'(bus.direction[1:0]), 8'h2);
        bus.stop = 1; tick("t6_stop"); bus.stop = 0;
        chk("t6_stop_state", 8'(bus.db_state), 8'h0);

        // random phase
        for (int n = 0; n < 3000; n++) begin
            restart      = ($urandom_range(0, 399) == 0);
            bus.stop     = ($urandom_range(0, 99) == 0);
            bus.start    = ($urandom_range(0, 19) == 0);
            bus.pause    = ($urandom_range(0, 29) == 0);
            bus.step     = ($urandom_range(0, 2) == 0);
            bus.init_dir = 4'($urandom);
            for (int p = 0; p < PLAYERS; p++) begin
                bus.up[p]    = ($urandom_range(0, 3) == 0);
                bus.down[p]  = ($urandom_range(0, 3) == 0);
                bus.left[p]  = ($urandom_range(0, 3) == 0);
                bus.right[p] = ($urandom_range(0, 3) == 0);
            end
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
